// File: rtl/logic_op_pipe.sv
// Pipelined bitwise logic unit: AND/OR/XOR/XNOR with optional operand-B and result complement,
// a zero flag, and a STAGES-deep valid/ready pipeline with back-pressure.
module logic_op_pipe #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [1:0]       op,
  input  logic             cmp_b,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] y,
  output logic             zero
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_op_pipe: STAGES must be in 1..4");
  end

  logic [0:WIDTH-1] b_eff;
  logic [0:WIDTH-1] res;
  logic [0:WIDTH-1] y_in;
  logic             z_in;

  always_comb begin
    b_eff = cmp_b ? ~b : b;
    case (op)
      2'b00:   res = a & b_eff;
      2'b01:   res = a | b_eff;
      2'b10:   res = a ^ b_eff;
      default: res = ~(a ^ b_eff);
    endcase
    y_in = neg ? ~res : res;
    z_in = (y_in == '0);
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] zr_q, zr_d;
  logic [STAGES-1:0] adv;
  logic [0:WIDTH-1]  dat_q [STAGES];
  logic [0:WIDTH-1]  dat_d [STAGES];
  logic              carry;

  // A stage may advance if it is empty or everything downstream of it can advance.
  always_comb begin
    carry = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      carry  = ~vld_q[i] | carry;
      adv[i] = carry;
    end
  end

  always_comb begin
    vld_d = vld_q;
    zr_d  = zr_q;
    dat_d = dat_q;
    if (adv[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = y_in;
        zr_d[0]  = z_in;
      end
    end
    // Bubbles only clear the valid bit; data registers keep their last payload.
    for (int i = 1; i < int'(STAGES); i++) begin
      if (adv[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
          zr_d[i]  = zr_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      zr_q  <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      zr_q  <= zr_d;
      for (int i = 0; i < int'(STAGES); i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[STAGES-1];
  assign y         = dat_q[STAGES-1];
  assign zero      = zr_q[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: directed literal cases plus randomized traffic scored
// against a truth-table model and an in-flight queue.
module tb_logic_op_pipe;
  localparam int unsigned W      = 24;
  localparam int unsigned STAGES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:W-1] a = '0;
  logic [0:W-1] b = '0;
  logic [1:0]   op = '0;
  logic         cmp_b = 1'b0;
  logic         neg = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:W-1] y;
  logic         zero;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cmp_b     (cmp_b),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero)
  );

  typedef struct {
    logic [0:W-1] y;
    logic         z;
    int           cyc;
    bit           clean;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   sent    = 0;
  int   target  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-bit truth table lookup, indexed by {a_bit, b_bit}.
  function automatic logic [0:W-1] model_y(input logic [0:W-1] av, input logic [0:W-1] bv,
                                           input logic [1:0] o, input logic c, input logic n);
    logic [3:0]   tt;
    logic [0:W-1] r;
    case (o)
      2'd0:    tt = 4'b1000;
      2'd1:    tt = 4'b1110;
      2'd2:    tt = 4'b0110;
      default: tt = 4'b1001;
    endcase
    for (int k = 0; k < int'(W); k++) begin
      logic bb;
      bb   = bv[k] ^ c;
      r[k] = tt[{av[k], bb}] ^ n;
    end
    return r;
  endfunction

  // Compare process: checks outputs every cycle and tracks what is in flight.
  logic [0:W-1] prev_y;
  logic         prev_z;
  bit           prev_stall = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_y", y, prev_y);
          check("hold_zero", zero, prev_z);
        end
        check("in_ready_rule", in_ready, out_ready || (q.size() < int'(STAGES)));
        if (q.size() == 0) begin
          check("idle_out_valid", out_valid, 0);
        end else begin
          if (q[0].clean && (cyc - q[0].cyc == int'(STAGES))) check("out_valid_due", out_valid, 1);
          if (out_valid) begin
            check("y", y, q[0].y);
            check("zero", zero, q[0].z);
            if (q[0].clean) check("latency", cyc - q[0].cyc, STAGES);
          end
        end
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          n_out++;
        end
        if (!out_ready) begin
          foreach (q[i]) q[i].clean = 1'b0;
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e.y     = model_y(a, b, op, cmp_b, neg);
          e.z     = (e.y == '0);
          e.cyc   = cyc;
          e.clean = 1'b1;
          q.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = y;
        prev_z     = zero;
      end
    end
  end

  task automatic drive(input logic [0:W-1] av, input logic [0:W-1] bv, input logic [1:0] o,
                       input logic c, input logic n);
    a = av; b = bv; op = o; cmp_b = c; neg = n; in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [31:0] ra, rb;
    ra = $urandom;
    rb = $urandom;
    if ($urandom_range(7) == 0) rb = ra;
    drive(ra[W-1:0], rb[W-1:0], 2'($urandom_range(3)), 1'($urandom_range(1)),
          1'($urandom_range(1)));
  endtask

  // One clock of streaming traffic; new operand set offered after each acceptance.
  task automatic step(input int rdy_pct, input bit always_valid, output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(99) < rdy_pct);
    if (acc) sent++;
    if (acc || !in_valid) begin
      if (sent < target && (always_valid || $urandom_range(3) != 0)) drive_rand();
      else in_valid = 1'b0;
    end
  endtask

  task automatic send_one(input string name, input logic [0:W-1] av, input logic [0:W-1] bv,
                          input logic [1:0] o, input logic c, input logic n,
                          input logic [0:W-1] ey, input logic ez);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(av, bv, o, c, n);
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k < int'(STAGES); k++) @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_y"}, y, ey);
    check({name, "_zero"}, zero, ez);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  logic [0:W-1] ys [3];
  int           at [3];
  int           got;
  int           acc_cnt;
  int           out0;
  bit           acc;

  initial begin
    // Pin the model itself against hand-computed values.
    check("model_xor", model_y(24'hF010FF, 24'hFFF000, 2'b10, 1'b0, 1'b0), 24'h0FE0FF);
    check("model_cmpb", model_y(24'hF010FF, 24'h000000, 2'b10, 1'b1, 1'b0), 24'h0FEF00);
    check("model_xnor", model_y(24'hF010FF, 24'hFFF000, 2'b11, 1'b0, 1'b0), 24'hF01F00);
    check("model_negand", model_y(24'h000000, 24'hFFFFFF, 2'b00, 1'b0, 1'b1), 24'hFFFFFF);

    // Reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_zero", zero, 0);
    check("rst_in_ready", in_ready, 1);

    send_one("xor", 24'hF010FF, 24'hFFF000, 2'b10, 1'b0, 1'b0, 24'h0FE0FF, 1'b0);
    send_one("xor_cmpb", 24'hF010FF, 24'h000000, 2'b10, 1'b1, 1'b0, 24'h0FEF00, 1'b0);

    // Back-to-back AND, OR, XNOR.
    got = 0;
    fork
      begin
        @(posedge clk); #1; drive(24'hF010FF, 24'hFFF000, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1; drive(24'hF010FF, 24'hFFF000, 2'b01, 1'b0, 1'b0);
        @(posedge clk); #1; drive(24'hF010FF, 24'hFFF000, 2'b11, 1'b0, 1'b0);
        @(posedge clk); #1; in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 12 && got < 3; t++) begin
          @(negedge clk);
          if (out_valid) begin
            ys[got] = y;
            at[got] = t;
            got++;
          end
        end
      end
    join
    check("b2b_count", got, 3);
    if (got == 3) begin
      check("b2b_and", ys[0], 24'hF01000);
      check("b2b_or", ys[1], 24'hFFF0FF);
      check("b2b_xnor", ys[2], 24'hF01F00);
      check("b2b_spacing", at[2] - at[0], 2);
    end

    send_one("and_neg", 24'h000000, 24'hFFFFFF, 2'b00, 1'b0, 1'b1, 24'hFFFFFF, 1'b0);
    send_one("xor_zero", 24'h123456, 24'h123456, 2'b10, 1'b0, 1'b0, 24'h000000, 1'b1);
    drain();

    // Stall: 6 ops offered with out_ready low, only STAGES may be accepted.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sent      = 0;
    target    = 6;
    drive_rand();
    acc_cnt = 0;
    out0    = n_out;
    for (int t = 0; t < 8; t++) begin
      step(0, 1'b1, acc);
      if (acc) acc_cnt++;
    end
    check("stall_accepts", acc_cnt, STAGES);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    for (int t = 0; t < 40 && sent < target; t++) step(100, 1'b1, acc);
    check("stall_sent", sent, 6);
    drain();
    check("stall_out_count", n_out - out0, 6);

    // Reset with a full pipe.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sent      = 0;
    target    = 10;
    drive_rand();
    for (int t = 0; t < 5; t++) step(0, 1'b1, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_y", y, 0);
    check("rst2_zero", zero, 0);
    check("rst2_in_ready", in_ready, 1);
    send_one("post_rst", 24'hF010FF, 24'hFFF000, 2'b10, 1'b0, 1'b0, 24'h0FE0FF, 1'b0);
    drain();

    // Randomized traffic with random back-pressure.
    @(posedge clk);
    #1;
    sent   = 0;
    target = 300;
    out0   = n_out;
    for (int t = 0; t < 5000 && sent < target; t++) step(70, 1'b0, acc);
    check("rand_sent", sent, 300);
    drain();
    check("rand_out_count", n_out - out0, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
